// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: stall/flush request and control bundle between the pipeline stages and pipe_ctrl
interface pipe_ctrl_if #(parameter int MULTI_LEN_W = 6);
    logic                   stallreq_id;
    logic                   stallreq_ex;
    logic                   ex_multi_start;
    logic [MULTI_LEN_W-1:0] ex_multi_len;
    logic                   flush_req;
    logic [31:0]            flush_pc;
    logic [5:0]             stall;
    logic                   flush;
    logic [31:0]            new_pc;
    logic                   multi_last;
    logic [31:0]            perf_stall_id;
    logic [31:0]            perf_stall_ex;

    modport master (
        output stallreq_id, stallreq_ex, ex_multi_start, ex_multi_len, flush_req, flush_pc,
        input  stall, flush, new_pc, multi_last, perf_stall_id, perf_stall_ex
    );

    modport slave (
        input  stallreq_id, stallreq_ex, ex_multi_start, ex_multi_len, flush_req, flush_pc,
        output stall, flush, new_pc, multi_last, perf_stall_id, perf_stall_ex
    );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush controller; stall cycle counters built only when PIPE_CTRL_PERF_EN is defined
module pipe_ctrl #(
    parameter int MULTI_LEN_W = 6
) (
    input logic       clk,
    input logic       rst,
    pipe_ctrl_if.slave bus
);
    localparam logic [5:0] STALL_EX = 6'b001111;
    localparam logic [5:0] STALL_ID = 6'b000111;

    typedef enum logic [1:0] {RUN, MULTI, FLUSH} state_t;

    state_t                 r_state;
    state_t                 w_state_nx;
    logic [MULTI_LEN_W-1:0] r_cnt;
    logic [MULTI_LEN_W-1:0] w_cnt_nx;
    logic [31:0]            r_pc;
    logic [31:0]            w_pc_nx;
    logic                   w_go;
    logic                   w_len1;

    // next-state and combinational stall/multi_last; a flush request overrides everything but reset
    always_comb begin
        w_go           = bus.ex_multi_start && (bus.ex_multi_len != '0);
        w_len1         = bus.ex_multi_start && (bus.ex_multi_len == MULTI_LEN_W'(1));
        w_state_nx     = r_state;
        w_cnt_nx       = r_cnt;
        w_pc_nx        = r_pc;
        bus.stall      = '0;
        bus.multi_last = 1'b0;
        if (bus.flush_req) begin
            w_state_nx = FLUSH;
            w_cnt_nx   = '0;
            w_pc_nx    = bus.flush_pc;
        end else begin
            case (r_state)
                RUN: begin
                    bus.stall      = (bus.stallreq_ex || w_go) ? STALL_EX : bus.stallreq_id ? STALL_ID : 6'b000000;
                    bus.multi_last = w_len1;
                    if (w_go && !w_len1) begin
                        w_state_nx = MULTI;
                        w_cnt_nx   = bus.ex_multi_len - MULTI_LEN_W'(2);
                    end
                end
                MULTI: begin
                    bus.stall      = STALL_EX;
                    bus.multi_last = (r_cnt == '0);
                    w_state_nx     = (r_cnt == '0) ? RUN : MULTI;
                    w_cnt_nx       = (r_cnt == '0) ? r_cnt : r_cnt - MULTI_LEN_W'(1);
                end
                default: w_state_nx = RUN;
            endcase
        end
        if (rst) begin
            bus.stall      = '0;
            bus.multi_last = 1'b0;
        end
    end

    assign bus.flush  = (r_state == FLUSH) && !rst;
    assign bus.new_pc = bus.flush ? r_pc : 32'd0;

    // state, hold counter and redirect PC registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
            r_cnt   <= '0;
            r_pc    <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_pc    <= w_pc_nx;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] r_perf_id;
    logic [31:0] r_perf_ex;

    // count cycles spent in decode and execute holds, wrapping naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_id <= '0;
            r_perf_ex <= '0;
        end else begin
            r_perf_id <= r_perf_id + ((bus.stall == STALL_ID) ? 32'd1 : 32'd0);
            r_perf_ex <= r_perf_ex + ((bus.stall == STALL_EX) ? 32'd1 : 32'd0);
        end
    end

    assign bus.perf_stall_id = rst ? 32'd0 : r_perf_id;
    assign bus.perf_stall_ex = rst ? 32'd0 : r_perf_ex;
`else
    assign bus.perf_stall_id = 32'd0;
    assign bus.perf_stall_ex = 32'd0;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: randomized scoreboard bench for pipe_ctrl against a hold/flush reference model
module tb_pipe_ctrl;
    localparam logic [5:0] EX = 6'b001111;
    localparam logic [5:0] ID = 6'b000111;

    typedef struct {
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] new_pc;
        logic        multi_last;
        logic [31:0] pid;
        logic [31:0] pex;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    exp_t q[$];

    int          m_hold = 0;
    bit          m_pend = 1'b0;
    logic [31:0] m_pc = '0;
    logic [31:0] m_pid = '0;
    logic [31:0] m_pex = '0;

    pipe_ctrl_if #(.MULTI_LEN_W(6)) bus ();

    pipe_ctrl #(.MULTI_LEN_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic cyc(input bit r, input bit id, input bit ex, input bit st, input int len,
                       input bit fr, input logic [31:0] fpc);
        exp_t e;
        @(posedge clk);
        #1;
        rst                = r;
        bus.stallreq_id    = id;
        bus.stallreq_ex    = ex;
        bus.ex_multi_start = st;
        bus.ex_multi_len   = 6'(len);
        bus.flush_req      = fr;
        bus.flush_pc       = fpc;
        if (r) begin
            e = '{6'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0};
        end else begin
            e.flush  = m_pend;
            e.new_pc = m_pend ? m_pc : 32'd0;
            e.pid    = m_pid;
            e.pex    = m_pex;
            if (fr || m_pend) e.stall = 6'b0;
            else if (m_hold > 0 || ex || (st && len > 0)) e.stall = EX;
            else if (id) e.stall = ID;
            else e.stall = 6'b0;
            e.multi_last = !fr && !m_pend && (m_hold == 1 || (m_hold == 0 && st && len == 1));
        end
        q.push_back(e);
        if (r) begin
            m_hold = 0;
            m_pend = 1'b0;
            m_pc   = '0;
            m_pid  = '0;
            m_pex  = '0;
        end else begin
`ifdef PIPE_CTRL_PERF_EN
            if (e.stall == EX) m_pex++;
            if (e.stall == ID) m_pid++;
`endif
            if (fr) begin
                m_pend = 1'b1;
                m_pc   = fpc;
                m_hold = 0;
            end else begin
                if (m_hold > 0) m_hold--;
                else if (!m_pend && st && len > 0) m_hold = len - 1;
                m_pend = 1'b0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 32'd0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("stall", 32'(bus.stall), 32'(e.stall));
                chk("flush", 32'(bus.flush), 32'(e.flush));
                chk("new_pc", bus.new_pc, e.new_pc);
                chk("multi_last", 32'(bus.multi_last), 32'(e.multi_last));
                chk("perf_stall_id", bus.perf_stall_id, e.pid);
                chk("perf_stall_ex", bus.perf_stall_ex, e.pex);
            end
        end
    end

    initial begin : stimulus
        bus.stallreq_id    = 1'b0;
        bus.stallreq_ex    = 1'b0;
        bus.ex_multi_start = 1'b0;
        bus.ex_multi_len   = '0;
        bus.flush_req      = 1'b0;
        bus.flush_pc       = '0;
        cyc(1, 0, 0, 0, 0, 0, 32'd0);
        cyc(1, 0, 0, 0, 0, 0, 32'd0);
        idle(2);
        cyc(0, 0, 0, 1, 10, 0, 32'd0);
        idle(2);
        cyc(1, 0, 0, 0, 0, 0, 32'd0);
        idle(3);
        cyc(0, 1, 0, 0, 0, 0, 32'd0);
        cyc(0, 1, 0, 0, 0, 0, 32'd0);
        idle(2);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0, 0, 32'd0);
        cyc(0, 1, 0, 1, 5, 0, 32'd0);
        for (int i = 0; i < 6; i++) cyc(0, 1, 0, 0, 0, 0, 32'd0);
        idle(1);
        cyc(0, 0, 0, 1, 8, 0, 32'd0);
        idle(2);
        cyc(0, 0, 0, 0, 0, 1, 32'h0000_0180);
        idle(3);
        cyc(0, 0, 0, 0, 0, 1, 32'h0000_0100);
        cyc(0, 0, 0, 0, 0, 1, 32'h0000_0200);
        idle(2);
        cyc(0, 0, 0, 1, 0, 0, 32'd0);
        cyc(0, 0, 0, 1, 1, 0, 32'd0);
        idle(2);
        cyc(0, 0, 0, 1, 63, 0, 32'd0);
        idle(64);
        cyc(0, 0, 0, 1, 2, 1, 32'h0000_0044);
        cyc(0, 0, 0, 1, 3, 0, 32'd0);
        idle(4);
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 6)),
                ($urandom_range(0, 19) == 0), $urandom);
        end
        idle(2);
        @(negedge clk);
        #1;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
